// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and index helpers for the memory-port arbiter.
// Channel indices are small unsigned values that wrap at the channel count.
package mem_port_arbiter_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_MBE_W  = DEF_DATA_W / 8;

    typedef int unsigned uint_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic                  read;
        logic                  write;
        logic [DEF_MBE_W-1:0]  mbe;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] wdata;
    } mem_req_t;

    // (a + b) mod n, valid while both operands are already below n
    function automatic uint_t wrap_add(uint_t a, uint_t b, uint_t n);
        uint_t s;
        s = a + b;
        return (s >= n) ? (s - n) : s;
    endfunction

    function automatic uint_t wrap_inc(uint_t idx, uint_t n);
        return wrap_add(idx, 32'd1, n);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_select.sv
// Combinational requester search: first requesting channel at or after ptr, wrapping.
// A pointer tied to zero gives plain lowest-index fixed priority.
module mem_port_arbiter_rr_select
    import mem_port_arbiter_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int IDX_W  = 1
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic [IDX_W-1:0]  grant,
    output logic              valid
);

    logic [IDX_W-1:0] idx;

    always_comb begin
        grant = '0;
        idx   = '0;
        valid = |req;
        // walk from the farthest offset back towards ptr so the nearest requester wins
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = IDX_W'(wrap_add(uint_t'(ptr), uint_t'(k), uint_t'(NUM_CH)));
            if (req[idx]) begin
                grant = idx;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// N-channel arbiter merging split core request ports onto one shared memory port.
// state | meaning:  IDLE - pick a requester | ISSUE - drive mem_* until mem_resp | RESP - pulse ch_resp[grant]
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int RR_MODE = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH-1:0]            ch_read,
    input  logic [NUM_CH-1:0]            ch_write,
    input  logic [NUM_CH*(DATA_W/8)-1:0] ch_mbe,
    input  logic [NUM_CH*ADDR_W-1:0]     ch_addr,
    input  logic [NUM_CH*DATA_W-1:0]     ch_wdata,
    output logic [NUM_CH-1:0]            ch_resp,
    output logic [DATA_W-1:0]            ch_rdata,
    output logic                         mem_read,
    output logic                         mem_write,
    output logic [DATA_W/8-1:0]          mem_mbe,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [DATA_W-1:0]            mem_wdata,
    input  logic                         mem_resp,
    input  logic [DATA_W-1:0]            mem_rdata
);

    localparam int MBE_W = DATA_W / 8;
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    arb_state_t        state_q, state_d;
    logic [IDX_W-1:0]  grant_q, ptr_q, sel_grant;
    logic              sel_valid;
    logic [NUM_CH-1:0] ch_req;

    logic              sel_read, sel_write;
    logic [MBE_W-1:0]  sel_mbe;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    logic              read_q, write_q;
    logic [MBE_W-1:0]  mbe_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, rdata_q;

    logic              capture, complete;

    assign ch_req = ch_read | ch_write;

    mem_port_arbiter_rr_select #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_select (
        .req   (ch_req),
        .ptr   (ptr_q),
        .grant (sel_grant),
        .valid (sel_valid)
    );

    always_comb begin
        sel_read  = 1'b0;
        sel_write = 1'b0;
        sel_mbe   = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel_grant == IDX_W'(i)) begin
                sel_read  = ch_read[i];
                sel_write = ch_write[i];
                sel_mbe   = ch_mbe[i*MBE_W +: MBE_W];
                sel_addr  = ch_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = ch_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign capture  = (state_q == IDLE) && sel_valid;
    assign complete = (state_q == ISSUE) && mem_resp;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        ch_resp   = '0;
        unique case (state_q)
            IDLE: begin
                if (sel_valid) state_d = ISSUE;
            end
            ISSUE: begin
                mem_read  = read_q;
                mem_write = write_q;
                if (mem_resp) state_d = RESP;
            end
            RESP: begin
                for (int i = 0; i < NUM_CH; i++) begin
                    ch_resp[i] = (grant_q == IDX_W'(i));
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // a write wins over a simultaneous read on the same channel
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_q <= '0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            mbe_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (capture) begin
            grant_q <= sel_grant;
            read_q  <= sel_read & ~sel_write;
            write_q <= sel_write;
            mbe_q   <= sel_mbe;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q <= '0;
        end else if (complete) begin
            rdata_q <= mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= '0;
        end else if ((RR_MODE != 0) && (state_q == RESP)) begin
            ptr_q <= IDX_W'(wrap_inc(uint_t'(grant_q), uint_t'(NUM_CH)));
        end
    end

    assign mem_mbe   = mbe_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign ch_rdata  = rdata_q;

endmodule
